// File: rtl/anim_screen_sequencer.sv
// Frame-by-frame animation sequencer: sweeps every pixel of a frame for plotting, holds, then advances.
// Define ANIM_SEQ_CLEAR_EN to insert a black clearing sweep before each frame's draw sweep.
module anim_screen_sequencer #(
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_W     = 160,
  parameter int FRAME_H     = 120,
  parameter int HOLD_CYCLES = 12500000,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int F_W         = 2,
  parameter int A_W         = 15
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           userCont,
  input  logic           loopMode,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [A_W-1:0] romAddr,
  output logic [F_W-1:0] frameSel,
  output logic           plot,
  output logic           black,
  output logic           busy,
  output logic           frameStart,
  output logic           done
);

  localparam int H_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CLEAR, S_DRAW, S_HOLD, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [A_W-1:0] addr_q, addr_d;
  logic [F_W-1:0] fsel_q, fsel_d;
  logic [H_W-1:0] hold_q, hold_d;
  logic           pend_q, pend_d;
  logic           plot_q, plot_d;
  logic           busy_q, busy_d;
  logic           fstart_q, fstart_d;
  logic           done_q, done_d;
  logic           last_px, hold_tc, adv, zero_ctr;

  assign last_px = (x_q == X_W'(FRAME_W - 1)) && (y_q == Y_W'(FRAME_H - 1));
  assign hold_tc = (hold_q == H_W'(HOLD_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    fsel_d   = fsel_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    adv      = 1'b0;
    zero_ctr = 1'b0;

    if (state_q != S_IDLE && userCont) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          fsel_d  = '0;
        end
      end
      S_INIT: begin
`ifdef ANIM_SEQ_CLEAR_EN
        state_d = S_CLEAR;
`else
        state_d = S_DRAW;
`endif
      end
`ifdef ANIM_SEQ_CLEAR_EN
      S_CLEAR: begin
        if (last_px) begin
          state_d  = S_DRAW;
          zero_ctr = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
`endif
      S_DRAW: begin
        if (last_px) begin
          state_d  = S_HOLD;
          zero_ctr = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      S_HOLD: begin
        // A pending user request overrides the hold terminal count.
        if (pend_q || userCont) begin
          state_d = S_DONE;
        end else if (hold_tc) begin
          if (fsel_q < F_W'(NUM_FRAMES - 1)) begin
            fsel_d  = fsel_q + F_W'(1);
            state_d = S_INIT;
          end else if (loopMode) begin
            fsel_d  = '0;
            state_d = S_INIT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          hold_d = hold_q + H_W'(1);
        end
      end
      S_DONE: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      addr_d = addr_q + A_W'(1);
      if (x_q == X_W'(FRAME_W - 1)) begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
    if (zero_ctr || state_d == S_INIT) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
      hold_d = '0;
    end
  end

  // Strobes are decoded from the next state so they line up with the registered counters.
  always_comb begin
    plot_d   = (state_d == S_DRAW) || (state_d == S_CLEAR);
    busy_d   = (state_d != S_IDLE);
    fstart_d = (state_d == S_INIT);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      fsel_q   <= '0;
      hold_q   <= '0;
      pend_q   <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      fstart_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      fsel_q   <= fsel_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      fstart_q <= fstart_d;
      done_q   <= done_d;
    end
  end

`ifdef ANIM_SEQ_CLEAR_EN
  logic black_q, black_d;
  assign black_d = (state_d == S_CLEAR);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) black_q <= 1'b0;
    else         black_q <= black_d;
  end
  assign black = black_q;
`else
  assign black = 1'b0;
`endif

  assign x          = x_q;
  assign y          = y_q;
  assign romAddr    = addr_q;
  assign frameSel   = fsel_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign frameStart = fstart_q;
  assign done       = done_q;

endmodule

// File: tb/tb_anim_screen_sequencer.sv
// Self-checking bench: per-cycle output trace compared against a frame-level schedule model.
module tb_anim_screen_sequencer;
  localparam int W = 4, H = 2, N = 3, HC = 5;
`ifdef ANIM_SEQ_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int FL = 1 + (CLR ? 2 : 1) * W * H + HC;  // cycles per frame

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, userCont = 1'b0, loopMode = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [14:0] romAddr;
  logic [1:0] frameSel;
  logic plot, black, busy, frameStart, done;

  anim_screen_sequencer #(.NUM_FRAMES(N), .FRAME_W(W), .FRAME_H(H), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .resetn(resetn), .start(start), .userCont(userCont), .loopMode(loopMode),
    .x(x), .y(y), .romAddr(romAddr), .frameSel(frameSel), .plot(plot), .black(black),
    .busy(busy), .frameStart(frameStart), .done(done));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // phase: 0 idle, 1 init, 2 clear, 3 draw, 4 hold, 5 done
  typedef struct packed {
    logic plot, black, busy, fs, dn;
    logic [1:0] fsel;
    logic [7:0] x;
    logic [6:0] y;
    logic [14:0] a;
    logic [2:0] ph;
    logic chk;
  } rec_t;
  rec_t exp_q[$];

  function automatic rec_t mk(input int ph, input int f, input int i);
    rec_t r;
    r = '0;
    r.ph = 3'(ph);
    r.fsel = 2'(f);
    r.busy = (ph != 0);
    r.fs = (ph == 1);
    r.dn = (ph == 5);
    r.plot = (ph == 2 || ph == 3);
    r.black = (ph == 2);
    r.chk = (ph >= 1 && ph <= 3);
    if (ph == 2 || ph == 3) begin
      r.x = 8'(i % W);
      r.y = 7'(i / W);
      r.a = 15'(i);
    end
    return r;
  endfunction

  // Schedule: each frame is INIT, optional clear sweep, draw sweep, up to HC hold cycles.
  task automatic build(input bit lm, input int uc, input int len);
    int f = 0;
    bit ended = 0;
    exp_q.delete();
    while (!ended && exp_q.size() < len) begin
      exp_q.push_back(mk(1, f, 0));
      if (CLR) for (int i = 0; i < W * H; i++) exp_q.push_back(mk(2, f, i));
      for (int i = 0; i < W * H; i++) exp_q.push_back(mk(3, f, i));
      for (int h = 0; h < HC; h++) begin
        exp_q.push_back(mk(4, f, 0));
        if (uc >= 0 && uc <= exp_q.size() - 1) begin
          exp_q.push_back(mk(5, f, 0));
          ended = 1;
          break;
        end
        if (h == HC - 1) begin
          if (f < N - 1) f++;
          else if (lm) f = 0;
          else begin
            exp_q.push_back(mk(5, f, 0));
            ended = 1;
          end
        end
      end
    end
    while (exp_q.size() < len) exp_q.push_back(mk(0, f, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; userCont = 0; resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic run_trace(input string nm, input bit lm, input int uc, input int len,
                           output int busy_cnt, output int done_cnt);
    rec_t e;
    busy_cnt = 0; done_cnt = 0;
    build(lm, uc, len);
    @(negedge clk);
    start = 1; loopMode = lm; userCont = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      e = exp_q[k];
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      total++;
      if ({plot, black, busy, frameStart, done, frameSel} !== {e.plot, e.black, e.busy, e.fs, e.dn, e.fsel} ||
          (e.chk && {x, y, romAddr} !== {e.x, e.y, e.a})) begin
        bad++;
        $display("FAIL %s cyc=%0d got p%b b%b bz%b fs%b d%b f%0d x%0d y%0d a%0d exp p%b b%b bz%b fs%b d%b f%0d x%0d y%0d a%0d",
                 nm, k, plot, black, busy, frameStart, done, frameSel, x, y, romAddr,
                 e.plot, e.black, e.busy, e.fs, e.dn, e.fsel, e.x, e.y, e.a);
      end
      start = (e.busy && !e.dn) ? 1'($urandom % 2) : 1'b0;
      userCont = (k == uc);
      loopMode = (e.ph == 3'd4) ? lm : 1'($urandom % 2);
    end
    start = 0; userCont = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    #2;
    total++;
    if ({x, y, romAddr, frameSel, plot, black, busy, frameStart, done} !== '0) begin
      bad++;
      $display("FAIL reset_state got %h exp 0", {x, y, romAddr, frameSel, plot, black, busy, frameStart, done});
    end
    do_reset();
  endtask

  task automatic test_one_shot();
    int bc, dc;
    run_trace("one_shot", 1'b0, -1, 3 * FL + 4, bc, dc);
    total++;
    if (bc !== 3 * FL + 1) begin
      bad++;
      $display("FAIL one_shot_busy_cycles got %0d exp %0d", bc, 3 * FL + 1);
    end
    total++;
    if (dc !== 1) begin
      bad++;
      $display("FAIL one_shot_done_count got %0d exp 1", dc);
    end
    do_reset();
  endtask

  task automatic test_loop();
    int bc, dc;
    run_trace("loop", 1'b1, -1, 3 * FL + 4, bc, dc);
    total++;
    if (dc !== 0) begin
      bad++;
      $display("FAIL loop_done_count got %0d exp 0", dc);
    end
    do_reset();
  endtask

  task automatic test_user_cont();
    int bc, dc;
    run_trace("user_cont", 1'b1, FL + 1 + (CLR ? W * H : 0) + 3, 2 * FL + 4, bc, dc);
    total++;
    if (frameSel !== 2'd1) begin
      bad++;
      $display("FAIL user_cont_fsel_kept got %0d exp 1", frameSel);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_draw();
    int bc, dc;
    build(1'b0, -1, 8);
    @(negedge clk);
    start = 1;
    for (int k = 0; k <= 1 + (CLR ? W * H : 0) + 5; k++) begin
      @(negedge clk);
      start = 0;
    end
    total++;
    if (!(plot === 1'b1 && romAddr === 15'd5)) begin
      bad++;
      $display("FAIL mid_draw_pre got plot=%b a=%0d exp plot=1 a=5", plot, romAddr);
    end
    #1 resetn = 0;
    #1;
    total++;
    if ({x, y, romAddr, frameSel, plot, black, busy, frameStart, done} !== '0) begin
      bad++;
      $display("FAIL async_reset got %h exp 0", {x, y, romAddr, frameSel, plot, black, busy, frameStart, done});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_done got %b exp 0", done);
      end
    end
    resetn = 1;
    run_trace("restart", 1'b0, -1, FL, bc, dc);
    do_reset();
  endtask

  task automatic test_random();
    int bc, dc, uc;
    bit lm;
    for (int n = 0; n < 6; n++) begin
      lm = 1'($urandom % 2);
      uc = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 3 * FL));
      run_trace("random", lm, uc, 3 * FL + 4, bc, dc);
      do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_loop();
    test_user_cont();
    test_reset_mid_draw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
